// File: rtl/i2c_slave_reg_controller.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_reg_controller
// Purpose  : Register-file front end for an I2C slave byte engine. It takes
//            a pointer byte, then writes to or reads from a small sync RAM.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_reg_controller #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Slave_Start,
    input  logic              Slave_RW,
    input  logic              Slave_RxValid,
    input  logic [DATA_W-1:0] Slave_RxData,
    input  logic              Slave_TxReq,
    input  logic              Slave_Stop,
    output logic [DATA_W-1:0] Slave_TxData,
    output logic              Slave_TxValid,
    output logic              Slave_ACK,
    output logic [ADDR_W-1:0] RAM_ADD,
    output logic [DATA_W-1:0] RAM_DIN,
    output logic              RAM_W,
    input  logic [DATA_W-1:0] RAM_RDOUT,
    output logic              Busy,
    output logic              Ptr_Error,
    output logic [5:0]        Byte_Count,
    output logic              Controller_Done
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GET_PTR    = 3'd1,
        WRITE_DATA = 3'd2,
        READ_FETCH = 3'd3,
        READ_LOAD  = 3'd4,
        READ_WAIT  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    state_t              r_state,    w_state;
    logic [ADDR_W-1:0]   r_ptr,      w_ptr;
    logic [ADDR_W-1:0]   r_ram_add,  w_ram_add;
    logic [DATA_W-1:0]   r_ram_din,  w_ram_din;
    logic                r_ram_w,    w_ram_w;
    logic [DATA_W-1:0]   r_tx_data,  w_tx_data;
    logic                r_tx_valid, w_tx_valid;
    logic                r_ack,      w_ack;
    logic                r_ptr_err,  w_ptr_err;
    logic [5:0]          r_byte_cnt, w_byte_cnt;
    logic                r_done,     w_done;
    logic [5:0]          w_cnt_inc;

    assign w_cnt_inc = (r_byte_cnt == 6'd63) ? r_byte_cnt : r_byte_cnt + 6'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_ram_add  <= '0;
            r_ram_din  <= '0;
            r_ram_w    <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_ack      <= 1'b0;
            r_ptr_err  <= 1'b0;
            r_byte_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_ptr      <= w_ptr;
            r_ram_add  <= w_ram_add;
            r_ram_din  <= w_ram_din;
            r_ram_w    <= w_ram_w;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_ack      <= w_ack;
            r_ptr_err  <= w_ptr_err;
            r_byte_cnt <= w_byte_cnt;
            r_done     <= w_done;
        end
    end

    // Start outranks Stop, and both outrank any byte event in the same cycle.
    always_comb begin
        w_state    = r_state;
        w_ptr      = r_ptr;
        w_ram_add  = r_ram_add;
        w_ram_din  = r_ram_din;
        w_ram_w    = 1'b0;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;
        w_ack      = 1'b0;
        w_ptr_err  = r_ptr_err;
        w_byte_cnt = r_byte_cnt;
        w_done     = 1'b0;

        if (Slave_Start) begin
            w_tx_valid = 1'b0;
            w_byte_cnt = '0;
            w_ptr_err  = 1'b0;
            if (Slave_RW) begin
                w_state   = READ_FETCH;
                w_ram_add = r_ptr;
            end else begin
                w_state   = GET_PTR;
            end
        end else if (Slave_Stop && (r_state != IDLE)) begin
            w_state    = IDLE;
            w_tx_valid = 1'b0;
            w_done     = 1'b1;
        end else begin
            case (r_state)
                GET_PTR: begin
                    if (Slave_RxValid) begin
                        w_ptr     = Slave_RxData[ADDR_W-1:0];
                        w_ptr_err = |Slave_RxData[DATA_W-1:ADDR_W];
                        w_ack     = 1'b1;
                        w_state   = WRITE_DATA;
                    end
                end
                WRITE_DATA: begin
                    if (Slave_RxValid) begin
                        w_ram_add  = r_ptr;
                        w_ram_din  = Slave_RxData;
                        w_ram_w    = 1'b1;
                        w_ack      = 1'b1;
                        w_ptr      = r_ptr + c_PTR_ONE;
                        w_byte_cnt = w_cnt_inc;
                    end
                end
                READ_FETCH: begin
                    // Address was registered on entry; RAM samples it at this edge.
                    w_ram_add = r_ptr;
                    w_state   = READ_LOAD;
                end
                READ_LOAD: begin
                    w_tx_data  = RAM_RDOUT;
                    w_tx_valid = 1'b1;
                    w_state    = READ_WAIT;
                end
                READ_WAIT: begin
                    if (Slave_TxReq) begin
                        w_tx_valid = 1'b0;
                        w_ptr      = r_ptr + c_PTR_ONE;
                        w_ram_add  = r_ptr + c_PTR_ONE;
                        w_byte_cnt = w_cnt_inc;
                        w_state    = READ_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Slave_TxData    = r_tx_data;
    assign Slave_TxValid   = r_tx_valid;
    assign Slave_ACK       = r_ack;
    assign RAM_ADD         = r_ram_add;
    assign RAM_DIN         = r_ram_din;
    assign RAM_W           = r_ram_w;
    assign Busy            = (r_state != IDLE);
    assign Ptr_Error       = r_ptr_err;
    assign Byte_Count      = r_byte_cnt;
    assign Controller_Done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_reg_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_reg_controller
// Purpose  : Scoreboard bench: directed I2C-side transactions against a sync RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_reg_controller;

    logic       clk;
    logic       reset;
    logic       Slave_Start, Slave_RW, Slave_RxValid, Slave_TxReq, Slave_Stop;
    logic [7:0] Slave_RxData;
    logic [7:0] Slave_TxData;
    logic       Slave_TxValid, Slave_ACK;
    logic [4:0] RAM_ADD;
    logic [7:0] RAM_DIN, RAM_RDOUT;
    logic       RAM_W, Busy, Ptr_Error, Controller_Done;
    logic [5:0] Byte_Count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_cyc;

    logic [12:0] q_wr[$];
    int          q_ack[$];
    logic [7:0]  q_tx_d[$];
    int          q_tx_c[$];
    int          q_done[$];

    logic [7:0] mem [0:31];
    logic       preload;
    logic       prev_txv;

    i2c_slave_reg_controller #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .Slave_Start(Slave_Start), .Slave_RW(Slave_RW),
        .Slave_RxValid(Slave_RxValid), .Slave_RxData(Slave_RxData),
        .Slave_TxReq(Slave_TxReq), .Slave_Stop(Slave_Stop),
        .Slave_TxData(Slave_TxData), .Slave_TxValid(Slave_TxValid),
        .Slave_ACK(Slave_ACK),
        .RAM_ADD(RAM_ADD), .RAM_DIN(RAM_DIN), .RAM_W(RAM_W), .RAM_RDOUT(RAM_RDOUT),
        .Busy(Busy), .Ptr_Error(Ptr_Error), .Byte_Count(Byte_Count),
        .Controller_Done(Controller_Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            mem[1]  <= 8'h77;
            mem[3]  <= 8'h5A;
            mem[4]  <= 8'hC3;
            mem[8]  <= 8'h42;
            mem[16] <= 8'h3C;
        end else if (RAM_W) begin
            mem[RAM_ADD] <= RAM_DIN;
        end
        RAM_RDOUT <= mem[RAM_ADD];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got unexpected event 0x%0h expected none", name, act);
    endtask

    // Monitor: pops an expectation each time the DUT presents an output event.
    always @(negedge clk) begin
        if (reset) begin
            if (RAM_W) begin
                if (q_wr.size() == 0) unexpected("ram_write", {19'd0, RAM_ADD, RAM_DIN});
                else chk("ram_write", {19'd0, RAM_ADD, RAM_DIN}, {19'd0, q_wr.pop_front()});
            end
            if (Slave_ACK) begin
                if (q_ack.size() == 0) unexpected("ack", 32'd1);
                else chk("ack", 32'd1, q_ack.pop_front());
            end
            if (Slave_TxValid && !prev_txv) begin
                if (q_tx_d.size() == 0) unexpected("tx_byte", {24'd0, Slave_TxData});
                else begin
                    chk("tx_byte", {24'd0, Slave_TxData}, {24'd0, q_tx_d.pop_front()});
                    chk("tx_latency", cyc, q_tx_c.pop_front());
                end
            end
            if (Controller_Done) begin
                if (q_done.size() == 0) unexpected("done", 32'd1);
                else chk("done", 32'd1, q_done.pop_front());
            end
        end
        prev_txv = Slave_TxValid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic rw);
        Slave_Start = 1'b1;
        Slave_RW    = rw;
        @(posedge clk);
        #1;
        last_cyc    = cyc;
        Slave_Start = 1'b0;
        Slave_RW    = 1'b0;
    endtask

    task automatic do_rx(input logic [7:0] d);
        Slave_RxData  = d;
        Slave_RxValid = 1'b1;
        tick(1);
        Slave_RxValid = 1'b0;
    endtask

    task automatic do_txreq();
        Slave_TxReq = 1'b1;
        @(posedge clk);
        #1;
        last_cyc    = cyc;
        Slave_TxReq = 1'b0;
    endtask

    task automatic do_stop();
        Slave_Stop = 1'b1;
        tick(1);
        Slave_Stop = 1'b0;
        q_done.push_back(1);
    endtask

    initial begin
        reset = 1'b0; preload = 1'b1; prev_txv = 1'b0;
        Slave_Start = 0; Slave_RW = 0; Slave_RxValid = 0; Slave_RxData = 0;
        Slave_TxReq = 0; Slave_Stop = 0;
        tick(3);
        chk("reset_ram", {18'd0, RAM_ADD, RAM_DIN, RAM_W}, 32'd0);
        chk("reset_tx", {22'd0, Slave_TxData, Slave_TxValid, Slave_ACK}, 32'd0);
        chk("reset_status", {23'd0, Busy, Ptr_Error, Byte_Count, Controller_Done}, 32'd0);
        preload = 1'b0;
        reset   = 1'b1;
        tick(2);

        // Pointer 5, two data bytes, stop
        do_start(1'b0);
        chk("busy_after_start", Busy, 1);
        do_rx(8'h05); q_ack.push_back(1);
        do_rx(8'hAA); q_ack.push_back(1); q_wr.push_back({5'd5, 8'hAA});
        do_rx(8'hBB); q_ack.push_back(1); q_wr.push_back({5'd6, 8'hBB});
        do_stop();
        tick(3);
        chk("count_two", Byte_Count, 2);
        chk("idle_after_stop", Busy, 0);
        chk("mem5", mem[5], 8'hAA);
        chk("mem6", mem[6], 8'hBB);

        // Pointer wrap 31 -> 0, then read back from pointer 1
        do_start(1'b0);
        do_rx(8'h1F); q_ack.push_back(1);
        do_rx(8'h11); q_ack.push_back(1); q_wr.push_back({5'd31, 8'h11});
        do_rx(8'h22); q_ack.push_back(1); q_wr.push_back({5'd0, 8'h22});
        do_stop();
        tick(2);
        chk("mem31", mem[31], 8'h11);
        chk("mem0", mem[0], 8'h22);
        do_start(1'b1); q_tx_d.push_back(8'h77); q_tx_c.push_back(last_cyc + 2);
        tick(3);
        do_stop();
        tick(2);

        // Write pointer 3, repeated start for read, ignored early TxReq
        do_start(1'b0);
        do_rx(8'h03); q_ack.push_back(1);
        do_start(1'b1); q_tx_d.push_back(8'h5A); q_tx_c.push_back(last_cyc + 2);
        tick(3);
        chk("count_before_txreq", Byte_Count, 0);
        do_txreq(); q_tx_d.push_back(8'hC3); q_tx_c.push_back(last_cyc + 2);
        chk("txvalid_cleared", Slave_TxValid, 0);
        do_txreq();
        tick(3);
        chk("count_one", Byte_Count, 1);
        do_stop();
        tick(1);
        chk("txvalid_stop", Slave_TxValid, 0);
        tick(2);

        // Pointer byte 0x25: error flag, pointer 5
        do_start(1'b0);
        do_rx(8'h25); q_ack.push_back(1);
        chk("ptr_error_set", Ptr_Error, 1);
        do_rx(8'h99); q_ack.push_back(1); q_wr.push_back({5'd5, 8'h99});
        do_start(1'b0);
        chk("ptr_error_cleared", Ptr_Error, 0);
        chk("count_cleared", Byte_Count, 0);
        do_stop();
        tick(2);

        // Stop coincident with a data byte: dropped, pointer stays at 0x10
        do_start(1'b0);
        do_rx(8'h10); q_ack.push_back(1);
        Slave_Stop = 1'b1; Slave_RxData = 8'hEE; Slave_RxValid = 1'b1;
        tick(1);
        Slave_Stop = 1'b0; Slave_RxValid = 1'b0;
        q_done.push_back(1);
        tick(2);
        chk("mem16_untouched", mem[16], 8'h3C);
        do_start(1'b1); q_tx_d.push_back(8'h3C); q_tx_c.push_back(last_cyc + 2);
        tick(3);

        // Reset during READ_WAIT takes effect without a clock
        chk("in_read_wait", Slave_TxValid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_txvalid", Slave_TxValid, 0);
        chk("async_busy", Busy, 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        do_start(1'b1); q_tx_d.push_back(8'h22); q_tx_c.push_back(last_cyc + 2);
        tick(3);
        do_stop();
        tick(2);

        // Reset right after a data byte is accepted: the write must not land
        do_start(1'b0);
        do_rx(8'h08); q_ack.push_back(1);
        Slave_RxData = 8'h55; Slave_RxValid = 1'b1;
        @(posedge clk);
        #1;
        Slave_RxValid = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_ram_w", RAM_W, 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("mem8_untouched", mem[8], 8'h42);

        tick(3);
        chk("queues_drained", q_wr.size() + q_ack.size() + q_tx_d.size() + q_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave_reg_controller.md
I2C_SLAVE_REG_CONTROLLER -- requirements
Module: i2c_slave_reg_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning register-RAM address width (32 entries).
REQ-002 SHALL have parameter DATA_W, default 8, meaning byte width.
REQ-003 SHALL use one clock and an asynchronous active-low reset (see REQ-004, REQ-005).
REQ-004 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port Slave_Start, input, 1, one-cycle pulse: own address matched, start or repeated start.
REQ-007 SHALL have port Slave_RW, input, 1, direction sampled with Slave_Start; 1 = master reads.
REQ-008 SHALL have port Slave_RxValid, input, 1, one-cycle pulse: Slave_RxData holds a received byte.
REQ-009 SHALL have port Slave_RxData, input, 8, received byte.
REQ-010 SHALL have port Slave_TxReq, input, 1, one-cycle pulse: engine consumed Slave_TxData.
REQ-011 SHALL have port Slave_Stop, input, 1, one-cycle pulse: stop condition seen.
REQ-012 SHALL have port Slave_TxData, output, 8, byte to transmit.
REQ-013 SHALL have port Slave_TxValid, output, 1, level: Slave_TxData is valid.
REQ-014 SHALL have port Slave_ACK, output, 1, one-cycle pulse: ACK the byte just received.
REQ-015 SHALL have ports RAM_ADD (output, 5, RAM address), RAM_DIN (output, 8, write data), RAM_W (output, 1, write strobe) and RAM_RDOUT (input, 8, synchronous read data, 1-cycle latency).
REQ-016 SHALL have ports Busy (output, 1, state not IDLE), Ptr_Error (output, 1, pointer byte exceeded 31), Byte_Count (output, 6, data bytes moved this transaction) and Controller_Done (output, 1, one-cycle pulse on stop).

Function
REQ-017 SHALL implement states IDLE, GET_PTR, WRITE_DATA, READ_FETCH, READ_LOAD and READ_WAIT.
REQ-018 In IDLE, on Slave_Start, SHALL go to GET_PTR if Slave_RW=0, else to READ_FETCH, and clear Byte_Count and Ptr_Error; Slave_RxValid and Slave_TxReq SHALL be ignored in IDLE.
REQ-019 In GET_PTR, on Slave_RxValid, SHALL set ptr to RxData[4:0], set Ptr_Error to |RxData[7:5], pulse Slave_ACK next cycle and go to WRITE_DATA; no RAM write.
REQ-020 In WRITE_DATA, on Slave_RxValid, SHALL drive RAM_ADD=ptr, RAM_DIN=RxData and RAM_W=1 for exactly the next cycle, pulse Slave_ACK that cycle, increment ptr and increment Byte_Count.
REQ-021 ptr SHALL wrap 31->0; Byte_Count SHALL saturate at 63.
REQ-022 ptr SHALL persist across transactions, so a read after write-pointer plus repeated start begins at the written pointer.
REQ-023 In READ_FETCH, SHALL drive RAM_ADD=ptr and go to READ_LOAD.
REQ-024 In READ_LOAD, SHALL capture RAM_RDOUT into Slave_TxData, set Slave_TxValid=1 and go to READ_WAIT; the first byte is valid 2 cycles after Slave_Start.
REQ-025 In READ_WAIT, on Slave_TxReq, SHALL clear Slave_TxValid, increment ptr and Byte_Count, and go to READ_FETCH; each next byte is valid 2 cycles after Slave_TxReq.
REQ-026 Slave_TxReq while Slave_TxValid=0 SHALL be ignored; the engine stretches SCL until Slave_TxValid=1.
REQ-027 RAM_W SHALL never assert outside the cycle after a WRITE_DATA Slave_RxValid.
REQ-028 Slave_Stop in any non-IDLE state SHALL go to IDLE, clear Slave_TxValid and pulse Controller_Done next cycle; Slave_Stop in IDLE SHALL do nothing.
REQ-029 Slave_Stop SHALL win over a simultaneous Slave_RxValid or Slave_TxReq: the byte is dropped and ptr is unchanged.
REQ-030 Slave_Start in a non-IDLE state (repeated start) SHALL act as in IDLE, keeping ptr and clearing Slave_TxValid, Byte_Count and Ptr_Error.
REQ-031 Slave_Start SHALL win over a simultaneous Slave_RxValid or Slave_TxReq.

Reset
REQ-032 While reset=0, SHALL force state IDLE, ptr=0 and all outputs 0 (RAM_ADD=0, RAM_DIN=0, RAM_W=0, Slave_TxData=0, Slave_TxValid=0, Slave_ACK=0, Busy=0, Ptr_Error=0, Byte_Count=0, Controller_Done=0).
REQ-033 Reset asserted mid-transaction SHALL abort without issuing any pending RAM write.

Verification
REQ-034 Bench SHALL cover: Start(RW=0), Rx 0x05, Rx 0xAA, Rx 0xBB, Stop -> RAM[5]=0xAA, RAM[6]=0xBB, Byte_Count=2, three ACK pulses, one Controller_Done pulse.
REQ-035 Bench SHALL cover: Start(RW=0), Rx 0x1F, Rx 0x11, Rx 0x22 -> writes to address 31 then address 0, ptr=1.
REQ-036 Bench SHALL cover: Start(RW=0), Rx 0x03, repeated Start(RW=1) with RAM[3]=0x5A -> TxData=0x5A with TxValid 2 cycles after Start; TxReq -> RAM[4] valid 2 cycles later.
REQ-037 Bench SHALL cover: Start(RW=0), Rx 0x25 -> Ptr_Error=1, ptr=5; next Start clears Ptr_Error.
REQ-038 Bench SHALL cover: Stop coincident with RxValid in WRITE_DATA -> no RAM_W, ptr unchanged, Controller_Done pulse.
REQ-039 Bench SHALL cover: reset=0 during READ_WAIT -> TxValid=0 and state IDLE immediately (asynchronously), ptr=0.
